// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg
//   Shared types and elaboration-time helpers for the tick scheduler.
//   - cfg_state_t     : config FSM states (IDLE, APPLY)
//   - calc_prescale() : board clocks per base tick (CLK_HZ / BASE_HZ)
//   - calc_ch_idx_w() : channel index width, never below 1 bit
package tick_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      APPLY = 1'b1
   } cfg_state_t;

   function automatic int calc_prescale(input int clk_hz, input int base_hz);
      return clk_hz / base_hz;
   endfunction

   function automatic int calc_ch_idx_w(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel
//   One programmable divider channel driven by the shared base tick.
//   Ports:
//     clk_100Mhz, rst : clock, async active-high reset
//     base_tick       : shared one-cycle base pulse
//     en              : run enable (level); when low count and clk_o hold
//     load            : write load_value into the period register, clear count
//     load_value      : new half-period in base ticks (0 parks the channel)
//     align           : clear count and force clk_o low (phase-align restart)
//     tick_o          : one-cycle pulse at each half-period expiry
//     clk_o           : divided clock, toggles with every tick_o
module tick_channel #(
   parameter int PERIOD_W       = 16,
   parameter int DEFAULT_PERIOD = 500
) (
   input  logic                clk_100Mhz,
   input  logic                rst,
   input  logic                base_tick,
   input  logic                en,
   input  logic                load,
   input  logic [PERIOD_W-1:0] load_value,
   input  logic                align,
   output logic                tick_o,
   output logic                clk_o
);

   logic [PERIOD_W-1:0] count;
   logic [PERIOD_W-1:0] period;
   logic                advance;
   logic                terminal;

   // A zero period behaves like a disabled channel, so period-1 never wraps
   // into a live compare value.
   assign advance  = base_tick & en & (period != '0);
   assign terminal = (count == (period - PERIOD_W'(1)));

   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         count  <= '0;
         period <= PERIOD_W'(DEFAULT_PERIOD);
         tick_o <= 1'b0;
         clk_o  <= 1'b0;
      end else begin
         tick_o <= 1'b0;
         if (align) begin
            count <= '0;
            clk_o <= 1'b0;
         end
         // A config write beats a coincident expiry: no tick, count restarts.
         if (load) begin
            period <= load_value;
            count  <= '0;
         end else if (advance && !align) begin
            if (terminal) begin
               count  <= '0;
               tick_o <= 1'b1;
               clk_o  <= ~clk_o;
            end else begin
               count <= count + PERIOD_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Shared timebase: one prescaler produces base_tick every PRESCALE clocks
//   and feeds NUM_CH independently programmable tick_channel instances.
//   Half-periods are rewritten at runtime through a valid/ready port.
//   Build option: define PHASE_ALIGN_EN to make every applied config write
//   restart all channels and the prescaler phase-aligned (all clk_o low).
//   Ports:
//     clk_100Mhz, rst : clock, async active-high reset
//     ch_en           : per-channel run enable
//     cfg_valid/ready : config handshake (transfer on valid & ready)
//     cfg_ch          : target channel; out-of-range writes are dropped
//     cfg_period      : new half-period in base ticks (0 parks the channel)
//     base_tick       : one-cycle pulse every PRESCALE clocks
//     tick_o, clk_o   : per-channel expiry pulse and divided clock
//
//   state | meaning
//   IDLE  | cfg_ready high, waiting for a handshake
//   APPLY | one cycle, captured write lands in the target channel
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int BASE_HZ        = 1_000,
   parameter int NUM_CH         = 4,
   parameter int PERIOD_W       = 16,
   parameter int DEFAULT_PERIOD = 500
) (
   input  logic                                clk_100Mhz,
   input  logic                                rst,
   input  logic [NUM_CH-1:0]                   ch_en,
   input  logic                                cfg_valid,
   output logic                                cfg_ready,
   input  logic [calc_ch_idx_w(NUM_CH)-1:0]    cfg_ch,
   input  logic [PERIOD_W-1:0]                 cfg_period,
   output logic                                base_tick,
   output logic [NUM_CH-1:0]                   tick_o,
   output logic [NUM_CH-1:0]                   clk_o
);

   localparam int PRESCALE = calc_prescale(CLK_HZ, BASE_HZ);
   localparam int CH_IDX_W = calc_ch_idx_w(NUM_CH);
   localparam int PSC_W    = $clog2(PRESCALE);

   cfg_state_t            state;
   cfg_state_t            state_nxt;
   logic                  apply;
   logic                  apply_valid;
   logic                  align;
   logic [CH_IDX_W-1:0]   cap_ch;
   logic [PERIOD_W-1:0]   cap_period;
   logic [PSC_W-1:0]      psc_cnt;
   logic                  psc_wrap;
   logic [NUM_CH-1:0]     load;

   // Prescaler
   assign psc_wrap = (psc_cnt == PSC_W'(PRESCALE - 1));

   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         psc_cnt   <= '0;
         base_tick <= 1'b0;
      end else if (align) begin
         psc_cnt   <= '0;
         base_tick <= 1'b0;
      end else begin
         base_tick <= psc_wrap;
         psc_cnt   <= psc_wrap ? '0 : psc_cnt + PSC_W'(1);
      end
   end

   // Config FSM
   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      apply     = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               state_nxt = APPLY;
            end
         end
         APPLY: begin
            apply     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         cap_ch     <= '0;
         cap_period <= '0;
      end else if (cfg_valid && cfg_ready) begin
         cap_ch     <= cfg_ch;
         cap_period <= cfg_period;
      end
   end

   // Writes to a non-existent channel complete the handshake but touch nothing.
   assign apply_valid = apply && (int'(cap_ch) < NUM_CH);

`ifdef PHASE_ALIGN_EN
   assign align = apply_valid;
`else
   assign align = 1'b0;
`endif

   // Channels
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = apply_valid && (cap_ch == CH_IDX_W'(i));

      tick_channel #(
         .PERIOD_W       (PERIOD_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
         .clk_100Mhz (clk_100Mhz),
         .rst        (rst),
         .base_tick  (base_tick),
         .en         (ch_en[i]),
         .load       (load[i]),
         .load_value (cap_period),
         .align      (align),
         .tick_o     (tick_o[i]),
         .clk_o      (clk_o[i])
      );
   end

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

   localparam int CLK_HZ         = 100;
   localparam int BASE_HZ        = 10;
   localparam int PRESCALE       = CLK_HZ / BASE_HZ;
   localparam int NUM_CH         = 5;
   localparam int PERIOD_W       = 16;
   localparam int DEFAULT_PERIOD = 3;
   localparam int CH_W           = 3;

   logic                clk_100Mhz = 1'b0;
   logic                rst = 1'b1;
   logic [NUM_CH-1:0]   ch_en = '1;
   logic                cfg_valid = 1'b0;
   logic                cfg_ready;
   logic [CH_W-1:0]     cfg_ch = '0;
   logic [PERIOD_W-1:0] cfg_period = '0;
   logic                base_tick;
   logic [NUM_CH-1:0]   tick_o;
   logic [NUM_CH-1:0]   clk_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state (values visible after the most recent edge)
   int                m_cnt [NUM_CH];
   int                m_per [NUM_CH];
   logic [NUM_CH-1:0] m_tick;
   logic [NUM_CH-1:0] m_clk;
   logic              m_base;
   int                m_ps;
   logic              m_busy;
   int                m_cap_ch;
   int                m_cap_p;

   tick_scheduler #(
      .CLK_HZ         (CLK_HZ),
      .BASE_HZ        (BASE_HZ),
      .NUM_CH         (NUM_CH),
      .PERIOD_W       (PERIOD_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
   ) dut (
      .clk_100Mhz (clk_100Mhz),
      .rst        (rst),
      .ch_en      (ch_en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .base_tick  (base_tick),
      .tick_o     (tick_o),
      .clk_o      (clk_o)
   );

   always #5 clk_100Mhz = ~clk_100Mhz;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_cnt[i] = 0;
         m_per[i] = DEFAULT_PERIOD;
      end
      m_tick = '0;
      m_clk  = '0;
      m_base = 1'b0;
      m_ps   = 0;
      m_busy = 1'b0;
      m_cap_ch = 0;
      m_cap_p  = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_update();
      logic              do_apply;
      logic              do_align;
      logic [NUM_CH-1:0] nt;
      logic              nb;
      nt = '0;
      do_apply = m_busy && (m_cap_ch < NUM_CH);
      do_align = 1'b0;
`ifdef PHASE_ALIGN_EN
      do_align = do_apply;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         if (do_apply && m_cap_ch == i) begin
            m_per[i] = m_cap_p;
            m_cnt[i] = 0;
         end else if (m_base && ch_en[i] && m_per[i] != 0 && !do_align) begin
            if (m_cnt[i] + 1 == m_per[i]) begin
               m_cnt[i] = 0;
               nt[i]    = 1'b1;
               m_clk[i] = ~m_clk[i];
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
      nb   = (m_ps == PRESCALE - 1);
      m_ps = (m_ps + 1) % PRESCALE;
      if (do_align) begin
         for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
         m_clk = '0;
         nt    = '0;
         nb    = 1'b0;
         m_ps  = 0;
      end
      m_tick = nt;
      m_base = nb;
      if (m_busy) begin
         m_busy = 1'b0;
      end else if (cfg_valid) begin
         m_busy   = 1'b1;
         m_cap_ch = int'(cfg_ch);
         m_cap_p  = int'(cfg_period);
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk_100Mhz);
      @(negedge clk_100Mhz);
      cyc++;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      cfg_valid  = 1'b0;
      cfg_ch     = '0;
      cfg_period = '0;
      ch_en      = '1;
      repeat (2) @(negedge clk_100Mhz);
      rst = 1'b0;
      model_reset();
      cyc = 0;
   endtask

   task automatic test_reset();
      @(negedge clk_100Mhz);
      checks++;
      if ({base_tick, cfg_ready, tick_o, clk_o} !== {1'b0, 1'b1, {NUM_CH{1'b0}}, {NUM_CH{1'b0}}}) begin
         errors++;
         $display("FAIL reset_values got base=%b rdy=%b tick=%b clk=%b exp 0 1 0 0", base_tick, cfg_ready, tick_o, clk_o);
      end
      do_reset();
      for (int k = 0; k < 35; k++) begin
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL reset_run cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
      end
      checks++;
      if (clk_o !== '1) begin
         errors++;
         $display("FAIL pre_async_clk got %b exp %b", clk_o, {NUM_CH{1'b1}});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({base_tick, cfg_ready, tick_o, clk_o} !== {1'b0, 1'b1, {NUM_CH{1'b0}}, {NUM_CH{1'b0}}}) begin
         errors++;
         $display("FAIL async_reset got base=%b rdy=%b tick=%b clk=%b exp 0 1 0 0", base_tick, cfg_ready, tick_o, clk_o);
      end
   endtask

   task automatic test_random();
      int hs;
      do_reset();
      hs = 0;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom);
         cfg_valid  = ($urandom_range(0, 9) < 3);
         cfg_ch     = CH_W'($urandom_range(0, 7));
         cfg_period = PERIOD_W'($urandom_range(0, 5));
         if (cfg_valid && !m_busy) hs++;
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL random cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
      end
      cfg_valid = 1'b0;
      checks++;
      if (hs == 0) begin
         errors++;
         $display("FAIL random_traffic handshakes got %0d exp >0", hs);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         cfg_valid  = 1'b1;
         cfg_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
         cfg_period = PERIOD_W'($urandom_range(1, 4));
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL b2b cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         checks++;
         if (cfg_ready !== ((cyc % 2) == 0)) begin
            errors++;
            $display("FAIL b2b_ready cyc=%0d got %b exp %b", cyc, cfg_ready, (cyc % 2) == 0);
         end
      end
      cfg_valid = 1'b0;
   endtask

`ifndef PHASE_ALIGN_EN
   task automatic test_default_run();
      do_reset();
      for (int k = 0; k < 70; k++) begin
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL default cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         if (cyc == 9 || cyc == 10 || cyc == 20) begin
            checks++;
            if (base_tick !== (cyc != 9)) begin
               errors++;
               $display("FAIL first_base cyc=%0d got %b exp %b", cyc, base_tick, cyc != 9);
            end
         end
         if (cyc == 31 || cyc == 61) begin
            checks++;
            if ({tick_o, clk_o} !== {{NUM_CH{1'b1}}, {NUM_CH{cyc == 31}}}) begin
               errors++;
               $display("FAIL default_tick cyc=%0d got tick=%b clk=%b", cyc, tick_o, clk_o);
            end
         end
      end
   endtask

   task automatic test_cfg_basic();
      do_reset();
      for (int k = 0; k < 35; k++) begin
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL cfg_basic cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         if (cyc == 6 || cyc == 7) begin
            checks++;
            if (cfg_ready !== (cyc == 7)) begin
               errors++;
               $display("FAIL cfg_ready cyc=%0d got %b exp %b", cyc, cfg_ready, cyc == 7);
            end
         end
         if (cyc == 11 || cyc == 21) begin
            checks++;
            if ({tick_o, clk_o[2]} !== {5'b00100, cyc == 11}) begin
               errors++;
               $display("FAIL ch2_fast cyc=%0d got tick=%b clk2=%b", cyc, tick_o, clk_o[2]);
            end
         end
         cfg_valid = (cyc == 5);
         if (cyc == 5) begin
            cfg_ch     = 3'd2;
            cfg_period = 16'd1;
         end
      end
   endtask

   task automatic test_enable_gap();
      do_reset();
      for (int k = 0; k < 70; k++) begin
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL en_gap cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         if (cyc > 25 && cyc < 61 && (tick_o[1] !== 1'b0 || clk_o[1] !== 1'b0)) begin
            errors++;
            $display("FAIL en_gap_hold cyc=%0d got tick1=%b clk1=%b exp 0 0", cyc, tick_o[1], clk_o[1]);
         end
         if (cyc == 31 || cyc == 61) begin
            checks++;
            if (tick_o !== ((cyc == 31) ? 5'b11101 : 5'b11111)) begin
               errors++;
               $display("FAIL en_gap_tick cyc=%0d got %b", cyc, tick_o);
            end
         end
         if (cyc == 25) ch_en[1] = 1'b0;
         if (cyc == 55) ch_en[1] = 1'b1;
      end
   endtask

   task automatic test_terminal_collision();
      do_reset();
      for (int k = 0; k < 65; k++) begin
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL collide cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         if (cyc == 31 || cyc == 61) begin
            checks++;
            if (tick_o[0] !== (cyc == 61) || tick_o[1] !== 1'b1) begin
               errors++;
               $display("FAIL collide_tick cyc=%0d got %b", cyc, tick_o);
            end
         end
         cfg_valid = (cyc == 29);
         if (cyc == 29) begin
            cfg_ch     = 3'd0;
            cfg_period = 16'd3;
         end
      end
   endtask

   task automatic test_oor_park();
      int bases;
      do_reset();
      bases = 0;
      for (int k = 0; k < 80; k++) begin
         step();
         if (base_tick === 1'b1) bases++;
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL oor_park cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         if (tick_o[3] !== 1'b0 || clk_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL parked_ch3 cyc=%0d got tick3=%b clk3=%b exp 0 0", cyc, tick_o[3], clk_o[3]);
         end
         if (cyc == 31) begin
            checks++;
            if (tick_o !== 5'b10111) begin
               errors++;
               $display("FAIL oor_tick cyc=%0d got %b exp 10111", cyc, tick_o);
            end
         end
         cfg_valid = (cyc == 3 || cyc == 6);
         cfg_ch     = (cyc == 3) ? 3'd5 : 3'd3;
         cfg_period = (cyc == 3) ? 16'd1 : 16'd0;
      end
      checks++;
      if (bases != 8) begin
         errors++;
         $display("FAIL base_continues got %0d exp 8", bases);
      end
   endtask

   task automatic test_reset_mid_apply();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cfg_valid  = (cyc == 3);
         cfg_ch     = 3'd1;
         cfg_period = 16'd7;
         step();
      end
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_apply_state got rdy=%b exp 0", cfg_ready);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_apply_reset got rdy=%b exp 1", cfg_ready);
      end
      model_reset();
      @(negedge clk_100Mhz);
      rst = 1'b0;
      cyc = 0;
      for (int k = 0; k < 35; k++) begin
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL mid_apply cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         if (cyc == 31) begin
            checks++;
            if (tick_o[1] !== 1'b1) begin
               errors++;
               $display("FAIL mid_apply_default got tick1=%b exp 1", tick_o[1]);
            end
         end
      end
   endtask
`else
   task automatic test_phase_align();
      do_reset();
      for (int k = 0; k < 50; k++) begin
         step();
         checks++;
         if ({base_tick, cfg_ready, tick_o, clk_o} !== {m_base, !m_busy, m_tick, m_clk}) begin
            errors++;
            $display("FAIL align cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, base_tick, cfg_ready, tick_o, clk_o, m_base, !m_busy, m_tick, m_clk);
         end
         if (cyc == 15 || cyc == 25) begin
            checks++;
            if ({base_tick, clk_o} !== {cyc == 25, {NUM_CH{1'b0}}}) begin
               errors++;
               $display("FAIL align_restart cyc=%0d got base=%b clk=%b", cyc, base_tick, clk_o);
            end
         end
         if (cyc == 46) begin
            checks++;
            if (tick_o !== '1) begin
               errors++;
               $display("FAIL align_sync cyc=%0d got %b exp all ones", cyc, tick_o);
            end
         end
         cfg_valid = (cyc == 13);
         cfg_ch     = 3'd0;
         cfg_period = 16'd3;
      end
   endtask
`endif

   initial begin
      test_reset();
`ifndef PHASE_ALIGN_EN
      test_default_run();
      test_cfg_basic();
      test_enable_gap();
      test_terminal_collision();
      test_oor_park();
      test_reset_mid_apply();
`else
      test_phase_align();
`endif
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
